// File: rtl/data_ary_xfer.sv
// data_ary_xfer: line-transfer engine between the cache controller and the data array SRAM
//   evict : read one array entry, stream it out low beat first on the memory write channel
//   refill: collect BEATS beats from the memory read channel, write the line with full strobe
// Ports:
//   i_clk, i_rst_n                         clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready/i_cmd_op/idx   command handshake (op 1 = evict, 0 = refill)
//   o_ary_ren/wen/wstrb/addr/wdata         array port, i_ary_rdata valid the cycle after ren
//   o_mw_valid/i_mw_ready/o_mw_data/last   memory write beat channel
//   i_mr_valid/o_mr_ready/i_mr_data/last   memory read beat channel
//   o_done, o_err                          completion pulse, refill last-marker mismatch pulse
module data_ary_xfer #(
    parameter int LINE_W = 128,
    parameter int BEAT_W = 64,
    parameter int IDX_W  = 7
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_op,
    input  logic [IDX_W-1:0]    i_cmd_idx,
    output logic                o_ary_ren,
    output logic                o_ary_wen,
    output logic [LINE_W/8-1:0] o_ary_wstrb,
    output logic [IDX_W-1:0]    o_ary_addr,
    output logic [LINE_W-1:0]   o_ary_wdata,
    input  logic [LINE_W-1:0]   i_ary_rdata,
    output logic                o_mw_valid,
    input  logic                i_mw_ready,
    output logic [BEAT_W-1:0]   o_mw_data,
    output logic                o_mw_last,
    input  logic                i_mr_valid,
    output logic                o_mr_ready,
    input  logic [BEAT_W-1:0]   i_mr_data,
    input  logic                i_mr_last,
    output logic                o_done,
    output logic                o_err
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, EV_RD, EV_CAP, EV_SEND, RF_RECV, RF_WR} state_t;

    state_t            state, nxt;
    logic [CW-1:0]     cnt;
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] line;
    logic              err;
    logic              last_beat;
    logic [31:0]       ofs;

    assign last_beat = cnt == CW'(BEATS - 1);
    assign ofs       = 32'(cnt) * 32'(BEAT_W);

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) state <= IDLE;
        else          state <= nxt;

    always_comb begin
        nxt         = state;
        o_cmd_ready = 1'b0;
        o_ary_ren   = 1'b0;
        o_ary_wen   = 1'b0;
        o_ary_wstrb = '0;
        o_ary_addr  = idx;
        o_ary_wdata = '0;
        o_mw_valid  = 1'b0;
        o_mw_data   = '0;
        o_mw_last   = 1'b0;
        o_mr_ready  = 1'b0;
        o_done      = 1'b0;
        o_err       = 1'b0;
        case (state)
            IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) nxt = i_cmd_op ? EV_RD : RF_RECV;
            end
            EV_RD: begin
                o_ary_ren = 1'b1;
                nxt       = EV_CAP;
            end
            EV_CAP: nxt = EV_SEND;
            EV_SEND: begin
                o_mw_valid = 1'b1;
                o_mw_data  = line[ofs +: BEAT_W];
                o_mw_last  = last_beat;
                if (i_mw_ready && last_beat) begin
                    o_done = 1'b1;
                    nxt    = IDLE;
                end
            end
            RF_RECV: begin
                o_mr_ready = 1'b1;
                // beat count, not the source's last marker, ends the refill
                if (i_mr_valid && last_beat) nxt = RF_WR;
            end
            RF_WR: begin
                o_ary_wen   = 1'b1;
                o_ary_wstrb = '1;
                o_ary_wdata = line;
                o_done      = 1'b1;
                o_err       = err;
                nxt         = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            cnt  <= '0;
            idx  <= '0;
            line <= '0;
            err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_cmd_valid) begin
                    idx <= i_cmd_idx;
                    cnt <= '0;
                    err <= 1'b0;
                end
                EV_CAP: begin
                    line <= i_ary_rdata;
                    cnt  <= '0;
                end
                EV_SEND: if (i_mw_ready) cnt <= last_beat ? '0 : cnt + 1'b1;
                RF_RECV: if (i_mr_valid) begin
                    line[ofs +: BEAT_W] <= i_mr_data;
                    // sticky: any beat whose marker disagrees with its position flags the line
                    err <= err | (i_mr_last != last_beat);
                    cnt <= last_beat ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_data_ary_xfer.sv
// tb_data_ary_xfer: directed self-checking bench for data_ary_xfer
module tb_data_ary_xfer;
    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_cmd_valid = 1'b0;
    logic         o_cmd_ready;
    logic         i_cmd_op = 1'b0;
    logic [6:0]   i_cmd_idx = '0;
    logic         o_ary_ren;
    logic         o_ary_wen;
    logic [15:0]  o_ary_wstrb;
    logic [6:0]   o_ary_addr;
    logic [127:0] o_ary_wdata;
    logic [127:0] i_ary_rdata = '0;
    logic         o_mw_valid;
    logic         i_mw_ready = 1'b0;
    logic [63:0]  o_mw_data;
    logic         o_mw_last;
    logic         i_mr_valid = 1'b0;
    logic         o_mr_ready;
    logic [63:0]  i_mr_data = '0;
    logic         i_mr_last = 1'b0;
    logic         o_done;
    logic         o_err;

    int checks = 0;
    int failures = 0;

    data_ary_xfer dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op), .i_cmd_idx(i_cmd_idx),
        .o_ary_ren(o_ary_ren), .o_ary_wen(o_ary_wen), .o_ary_wstrb(o_ary_wstrb), .o_ary_addr(o_ary_addr),
        .o_ary_wdata(o_ary_wdata), .i_ary_rdata(i_ary_rdata),
        .o_mw_valid(o_mw_valid), .i_mw_ready(i_mw_ready), .o_mw_data(o_mw_data), .o_mw_last(o_mw_last),
        .i_mr_valid(i_mr_valid), .o_mr_ready(o_mr_ready), .i_mr_data(i_mr_data), .i_mr_last(i_mr_last),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic refill_beat(input logic [63:0] d, input logic l);
        i_mr_valid = 1'b1;
        i_mr_data  = d;
        i_mr_last  = l;
        #1 chk("rf_mr_ready", o_mr_ready, 1);
        step();
        i_mr_valid = 1'b0;
        i_mr_last  = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_outs", {o_ary_ren, o_ary_wen, o_mw_valid, o_mr_ready, o_done, o_err}, 0);
        chk("rst_addr", o_ary_addr, 0);
        i_rst_n = 1'b1;
        step();

        // evict 0x45, ready held high
        i_cmd_valid = 1'b1; i_cmd_op = 1'b1; i_cmd_idx = 7'h45;
        i_ary_rdata = {64'h1111111111111111, 64'h2222222222222222};
        i_mw_ready  = 1'b1;
        step();
        i_cmd_valid = 1'b0;
        chk("ev1_ren", {o_ary_ren, o_ary_wen}, 2'b10);
        chk("ev1_addr", o_ary_addr, 7'h45);
        chk("ev1_busy", o_cmd_ready, 0);
        step();
        chk("ev1_cap_quiet", {o_ary_ren, o_mw_valid, o_done}, 0);
        step();
        chk("ev1_b0", {o_mw_valid, o_mw_last, o_done, o_mw_data}, {3'b100, 64'h2222222222222222});
        step();
        chk("ev1_b1", {o_mw_valid, o_mw_last, o_done, o_mw_data}, {3'b111, 64'h1111111111111111});
        step();
        chk("ev1_idle", {o_cmd_ready, o_mw_valid, o_done}, 3'b100);

        // evict with backpressure on beat 0
        i_cmd_valid = 1'b1; i_cmd_op = 1'b1; i_cmd_idx = 7'h12;
        i_ary_rdata = {64'h3333333333333333, 64'h4444444444444444};
        i_mw_ready  = 1'b0;
        step();
        i_cmd_valid = 1'b0;
        chk("ev2_addr", o_ary_addr, 7'h12);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chk("ev2_hold", {o_mw_valid, o_mw_last, o_done, o_mw_data}, {3'b100, 64'h4444444444444444});
            step();
        end
        i_mw_ready = 1'b1;
        #1 chk("ev2_b0", {o_mw_valid, o_mw_last, o_done, o_mw_data}, {3'b100, 64'h4444444444444444});
        step();
        chk("ev2_b1", {o_mw_valid, o_mw_last, o_done, o_mw_data}, {3'b111, 64'h3333333333333333});
        step();
        chk("ev2_idle", {o_cmd_ready, o_mw_valid}, 2'b10);

        // refill 0x7F, correct last marker
        i_cmd_valid = 1'b1; i_cmd_op = 1'b0; i_cmd_idx = 7'h7F;
        step();
        i_cmd_valid = 1'b0;
        chk("rf1_no_mw", o_mw_valid, 0);
        refill_beat(64'hAAAA000000000001, 1'b0);
        chk("rf1_no_wen_mid", o_ary_wen, 0);
        refill_beat(64'hBBBB000000000002, 1'b1);
        chk("rf1_wr", {o_ary_wen, o_ary_ren, o_mr_ready, o_done, o_err}, 5'b10010);
        chk("rf1_addr", o_ary_addr, 7'h7F);
        chk("rf1_wstrb", o_ary_wstrb, 16'hFFFF);
        chk("rf1_wdata", o_ary_wdata, {64'hBBBB000000000002, 64'hAAAA000000000001});
        step();
        chk("rf1_idle", {o_cmd_ready, o_ary_wen, o_ary_wstrb, o_done}, {2'b10, 16'h0, 1'b0});

        // refill with early last marker and valid gaps
        i_cmd_valid = 1'b1; i_cmd_op = 1'b0; i_cmd_idx = 7'h10;
        step();
        i_cmd_valid = 1'b0;
        step();
        chk("rf2_gap", {o_mr_ready, o_ary_wen}, 2'b10);
        refill_beat(64'hC0C0C0C0C0C0C0C0, 1'b1);
        chk("rf2_early_last", {o_mr_ready, o_ary_wen, o_done}, 3'b100);
        step();
        refill_beat(64'hD0D0D0D0D0D0D0D0, 1'b0);
        chk("rf2_wr", {o_ary_wen, o_done, o_err}, 3'b111);
        chk("rf2_wdata", o_ary_wdata, {64'hD0D0D0D0D0D0D0D0, 64'hC0C0C0C0C0C0C0C0});
        step();
        chk("rf2_err_pulse", {o_ary_wen, o_done, o_err}, 0);

        // reset during EV_SEND after beat 0 accepted
        i_cmd_valid = 1'b1; i_cmd_op = 1'b1; i_cmd_idx = 7'h33;
        i_ary_rdata = {64'h5555555555555555, 64'h6666666666666666};
        i_mw_ready  = 1'b1;
        step();
        i_cmd_valid = 1'b0;
        step();
        step();
        step();
        chk("rs_pre", {o_mw_valid, o_mw_data}, {1'b1, 64'h5555555555555555});
        i_rst_n = 1'b0;
        #1;
        chk("rs_outs", {o_mw_valid, o_mw_last, o_done, o_ary_ren, o_ary_wen, o_mr_ready}, 0);
        chk("rs_ready", o_cmd_ready, 1);
        chk("rs_addr", o_ary_addr, 0);
        step();
        chk("rs_no_wen", o_ary_wen, 0);
        i_rst_n = 1'b1;
        step();
        i_cmd_valid = 1'b1; i_cmd_op = 1'b0; i_cmd_idx = 7'h22;
        step();
        i_cmd_valid = 1'b0;
        refill_beat(64'h0123456789ABCDEF, 1'b0);
        refill_beat(64'hFEDCBA9876543210, 1'b1);
        chk("rs_rf_wr", {o_ary_wen, o_done, o_err, o_ary_addr}, {3'b110, 7'h22});
        chk("rs_rf_wdata", o_ary_wdata, {64'hFEDCBA9876543210, 64'h0123456789ABCDEF});
        step();

        // command held valid during an evict
        i_cmd_valid = 1'b1; i_cmd_op = 1'b1; i_cmd_idx = 7'h05;
        i_ary_rdata = {64'h7777777777777777, 64'h8888888888888888};
        step();
        i_cmd_op = 1'b0; i_cmd_idx = 7'h06;
        for (int i = 0; i < 3; i++) begin
            chk("bb_held", {o_cmd_ready, o_ary_addr}, {1'b0, 7'h05});
            step();
        end
        chk("bb_done", {o_cmd_ready, o_done, o_mw_last}, 3'b011);
        step();
        chk("bb_accept", {o_cmd_ready, o_done}, 2'b10);
        step();
        i_cmd_valid = 1'b0;
        chk("bb_rf_addr", {o_mr_ready, o_ary_addr}, {1'b1, 7'h06});
        refill_beat(64'h9999999999999999, 1'b0);
        refill_beat(64'hAAAAAAAAAAAAAAAA, 1'b1);
        chk("bb_rf_wr", {o_ary_wen, o_done, o_err, o_ary_addr}, {3'b110, 7'h06});
        step();
        chk("bb_end", o_cmd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
